serial_to_parallel_rx: RTL and testbench

Receive end of the team's serial shift link: collects a serial bit stream, as emitted by the universal shift register in shift-right or shift-left mode, into N-bit parallel words. Frames are delimited by a start strobe. Bit order is selectable per frame. Completed words are presented on a valid/ready output port with overrun and framing-error flags. Sits between the serial link and the parallel consumer logic.

---
 rtl/serial_to_parallel_rx_if.sv | 26 ++
 rtl/serial_to_parallel_rx.sv | 103 ++++++++++
 tb/tb_serial_to_parallel_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_rx_if.sv
// Bundle of the serial link input and the parallel valid/ready output of the receiver.
// master = link driver plus word consumer, slave = the receiver itself.
interface serial_to_parallel_rx_if #(
    parameter int N = 4
);
    logic         ser_in;
    logic         ser_valid;
    logic         frame_start;
    logic         msb_first;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    modport master (
        output ser_in, ser_valid, frame_start, msb_first, data_ready,
        input  data_out, data_valid, busy, overrun, frame_err
    );

    modport slave (
        input  ser_in, ser_valid, frame_start, msb_first, data_ready,
        output data_out, data_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Collects framed serial bits into N-bit words (MSB- or LSB-first per frame) and
// offers them on a valid/ready port with overrun and framing-error pulses.
module serial_to_parallel_rx #(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    serial_to_parallel_rx_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_shreg;
    logic [N-1:0]   r_data;
    logic [CW-1:0]  r_count;
    logic           r_msb;
    logic           r_valid;
    logic           r_overrun;
    logic           r_frame_err;

    logic           w_accept;
    logic           w_start;
    logic           w_last;
    logic [N-1:0]   w_shifted;
    logic [N-1:0]   w_first;

    always_comb begin
        w_accept  = bus.ser_valid;
        w_start   = bus.ser_valid & bus.frame_start;
        // The N-th bit always completes its frame, even if frame_start rides on it.
        w_last    = (r_state == SHIFT) && bus.ser_valid && (r_count == CW'(N - 1));
        w_shifted = r_msb ? {r_shreg[N-2:0], bus.ser_in}
                          : {bus.ser_in, r_shreg[N-1:1]};
        w_first   = bus.msb_first ? {{(N-1){1'b0}}, bus.ser_in}
                                  : {bus.ser_in, {(N-1){1'b0}}};
    end

    // Flops move on the falling edge to line up with the transmit-side shifter.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_data      <= '0;
            r_count     <= '0;
            r_msb       <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_msb   <= bus.msb_first;
                        r_shreg <= w_first;
                        r_count <= CW'(1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_shreg <= w_shifted;
                        r_count <= '0;
                        r_state <= IDLE;
                    end else if (w_start) begin
                        r_frame_err <= 1'b1;
                        r_msb       <= bus.msb_first;
                        r_shreg     <= w_first;
                        r_count     <= CW'(1);
                    end else if (w_accept) begin
                        r_shreg <= w_shifted;
                        r_count <= r_count + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_last) begin
                if (!r_valid || bus.data_ready) begin
                    r_data  <= w_shifted;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.busy       = (r_state == SHIFT);
    assign bus.overrun    = r_overrun;
    assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: directed frames plus random traffic, checked every
// cycle against a frame-level model built from bit lists.
module tb_serial_to_parallel_rx;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    serial_to_parallel_rx_if #(.N(N)) bus_if ();

    serial_to_parallel_rx #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of received bits; the word is assembled by weight.
    bit           q[$];
    bit           m_order = 1'b0;
    logic [N-1:0] m_data  = '0;
    bit           m_valid = 1'b0;
    bit           m_ovr   = 1'b0;
    bit           m_ferr  = 1'b0;

    function automatic logic [N-1:0] assemble(input bit msb);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (msb) w[N-1-i] = q[i];
            else     w[i]     = q[i];
        end
        return w;
    endfunction

    always @(negedge clk or negedge reset_n) begin
        bit           done;
        logic [N-1:0] word;
        if (!reset_n) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            done   = 1'b0;
            word   = '0;
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            if (bus_if.ser_valid) begin
                if (q.size() == 0) begin
                    if (bus_if.frame_start) begin
                        m_order = bus_if.msb_first;
                        q.push_back(bus_if.ser_in);
                    end
                end else if (bus_if.frame_start && q.size() < N - 1) begin
                    m_ferr  = 1'b1;
                    q.delete();
                    m_order = bus_if.msb_first;
                    q.push_back(bus_if.ser_in);
                end else begin
                    q.push_back(bus_if.ser_in);
                    if (q.size() == N) begin
                        done = 1'b1;
                        word = assemble(m_order);
                        q.delete();
                    end
                end
            end
            if (done) begin
                if (!m_valid || bus_if.data_ready) begin
                    m_data  = word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && bus_if.data_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (run_cmp) begin
            check("data_out",   bus_if.data_out,   m_data);
            check("data_valid", bus_if.data_valid, m_valid);
            check("busy",       bus_if.busy,       q.size() != 0);
            check("overrun",    bus_if.overrun,    m_ovr);
            check("frame_err",  bus_if.frame_err,  m_ferr);
        end
    end

    task automatic send_bit(input bit b, input bit fs, input bit msb);
        bus_if.ser_in      = b;
        bus_if.ser_valid   = 1'b1;
        bus_if.frame_start = fs;
        bus_if.msb_first   = msb;
        @(posedge clk);
        bus_if.ser_valid   = 1'b0;
        bus_if.frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        bus_if.ser_in      = 1'b0;
        bus_if.ser_valid   = 1'b0;
        bus_if.frame_start = 1'b0;
        bus_if.msb_first   = 1'b0;
        bus_if.data_ready  = 1'b1;
        reset_n            = 1'b0;

        // Reset held with link activity
        @(negedge clk);
        run_cmp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            bus_if.ser_valid   = ~bus_if.ser_valid;
            bus_if.frame_start = 1'b1;
            bus_if.ser_in      = 1'b1;
        end
        @(posedge clk);
        check("rst_data",  bus_if.data_out, 0);
        check("rst_valid", bus_if.data_valid, 0);
        check("rst_busy",  bus_if.busy, 0);
        bus_if.ser_valid   = 1'b0;
        bus_if.frame_start = 1'b0;
        reset_n = 1'b1;
        idle(5);
        check("idle_data",  bus_if.data_out, 0);
        check("idle_valid", bus_if.data_valid, 0);

        // LSB-first 1,0,1,1 -> D
        send_bit(1, 1, 0);
        check("lsb_busy1", bus_if.busy, 1);
        send_bit(0, 0, 1);
        send_bit(1, 0, 1);
        check("lsb_busy3", bus_if.busy, 1);
        send_bit(1, 0, 1);
        check("lsb_data",  bus_if.data_out, 4'hD);
        check("lsb_model", m_data, 4'hD);
        check("lsb_valid", bus_if.data_valid, 1);
        check("lsb_busy4", bus_if.busy, 0);
        idle(1);
        check("lsb_valid_drop", bus_if.data_valid, 0);

        // MSB-first 1,0,1,1 with gaps -> B
        send_bit(1, 1, 1);
        idle(2);
        send_bit(0, 0, 0);
        idle(2);
        check("gap_busy", bus_if.busy, 1);
        send_bit(1, 0, 0);
        idle(2);
        send_bit(1, 0, 0);
        check("msb_data",  bus_if.data_out, 4'hB);
        check("msb_model", m_data, 4'hB);
        idle(2);

        // Overrun: A held, 5 dropped
        bus_if.data_ready = 1'b0;
        send_bit(1, 1, 1); send_bit(0, 0, 1); send_bit(1, 0, 1); send_bit(0, 0, 1);
        check("ovr_first", bus_if.data_out, 4'hA);
        send_bit(0, 1, 1); send_bit(1, 0, 1); send_bit(0, 0, 1); send_bit(1, 0, 1);
        check("ovr_pulse", bus_if.overrun, 1);
        check("ovr_model", m_ovr, 1);
        check("ovr_keep",  bus_if.data_out, 4'hA);
        idle(1);
        check("ovr_clear", bus_if.overrun, 0);
        send_bit(0, 1, 1); send_bit(1, 0, 1); send_bit(0, 0, 1);
        bus_if.data_ready = 1'b1;
        send_bit(1, 0, 1);
        check("ready_data", bus_if.data_out, 4'h5);
        check("ready_novr", bus_if.overrun, 0);
        idle(2);

        // Abort after 2 bits, restart with 1,0,0,1 -> 9
        send_bit(1, 1, 1);
        send_bit(1, 0, 1);
        send_bit(1, 1, 1);
        check("abort_ferr", bus_if.frame_err, 1);
        check("abort_busy", bus_if.busy, 1);
        send_bit(0, 0, 1);
        check("abort_once", bus_if.frame_err, 0);
        send_bit(0, 0, 1);
        send_bit(1, 0, 1);
        check("abort_data",  bus_if.data_out, 4'h9);
        check("abort_model", m_data, 4'h9);
        idle(2);

        // Async reset mid-frame, then LSB-first 0,1,1,0 -> 6
        send_bit(1, 1, 0);
        send_bit(0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy",  bus_if.busy, 0);
        check("arst_valid", bus_if.data_valid, 0);
        @(posedge clk);
        reset_n = 1'b1;
        send_bit(0, 1, 0); send_bit(1, 0, 1); send_bit(1, 0, 1); send_bit(0, 0, 1);
        check("arst_data",  bus_if.data_out, 4'h6);
        check("arst_model", m_data, 4'h6);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus_if.ser_valid   = ($urandom_range(0, 9) < 6);
            bus_if.ser_in      = 1'($urandom);
            bus_if.frame_start = ($urandom_range(0, 9) < 2);
            bus_if.msb_first   = 1'($urandom);
            bus_if.data_ready  = 1'($urandom);
            @(posedge clk);
        end
        bus_if.ser_valid = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
